audio_sfx_scheduler: RTL
========================

AUDIO_SFX_SCHEDULER -- requirements
Module: audio_sfx_scheduler

Interface
REQ-001 Parameter AMPLITUDE, default 32'd50000000, sets the square-wave peak magnitude of the signed sample.
REQ-002 Parameter GAP_CYCLES, default 32'd15000000, sets the silent gap between consecutive sounds (0.3 s at 50 MHz).
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 enable  in  1  scheduler run enable; low aborts playback.
REQ-006 req_valid  in  3  per-requester sound request; index 0 is highest priority.
REQ-007 req_half_period  in  57  three 19-bit tone half-periods in clocks; requester i occupies bits [19i+18:19i].
REQ-008 req_duration  in  78  three 26-bit durations in clocks; requester i occupies bits [26i+25:26i].
REQ-009 req_accept  out  3  one-cycle pulse when a request is granted.
REQ-010 req_done  out  3  one-cycle pulse when a granted sound completes normally.
REQ-011 busy  out  1  high in PLAY or GAP.
REQ-012 active_id  out  2  index of the requester being played; 2'd3 when none.
REQ-013 audio_out_allowed  in  1  audio controller output-FIFO space indication.
REQ-014 write_audio_out  out  1  sample write strobe to the audio controller.
REQ-015 left_channel_audio_out, right_channel_audio_out  out  32 each  signed sample; both channels identical.

Function
REQ-016 FSM states SHALL be IDLE, PLAY and GAP.
REQ-017 IDLE->PLAY SHALL occur on the edge where enable=1 and any req_valid=1; the grant goes to the lowest set index.
REQ-018 At that edge the granted half-period and duration SHALL be latched; later changes to the request inputs SHALL NOT affect the sound.
REQ-019 req_accept[i] SHALL be high exactly in the first PLAY cycle.
REQ-020 Requests arriving in PLAY or GAP SHALL NOT be accepted; a requester holding valid SHALL be arbitrated at the next IDLE edge.
REQ-021 A valid dropped before acceptance SHALL leave no record.
REQ-022 PLAY SHALL last exactly D cycles, where D is the latched duration; a duration of 0 SHALL be treated as 1.
REQ-023 Tone phase SHALL be 1 on PLAY entry with the tone counter at 0.
REQ-024 Each PLAY cycle: if counter == H-1, counter SHALL return to 0 and phase SHALL toggle; otherwise counter SHALL increment. H is the latched half-period; 0 is treated as 1.
REQ-025 In PLAY, sample SHALL be +AMPLITUDE when phase=1 and -AMPLITUDE (two's complement) when phase=0.
REQ-026 In IDLE and GAP, sample SHALL be 0.
REQ-027 After the last PLAY cycle the FSM SHALL enter GAP for GAP_CYCLES cycles and then return to IDLE.
REQ-028 If GAP_CYCLES=0, PLAY SHALL go directly to IDLE.
REQ-029 req_done[i] SHALL pulse in the first cycle after the last PLAY cycle, whether that cycle is GAP or IDLE.
REQ-030 With GAP_CYCLES=0, a pending request SHALL be granted at the edge ending that first IDLE cycle, i.e. back-to-back.
REQ-031 enable=0 in any state SHALL force IDLE at the next edge, zero the sample, set active_id=3, and issue no req_done.
REQ-032 write_audio_out SHALL equal audio_out_allowed AND enable (combinational), so samples stream continuously, including zeros.
REQ-033 active_id SHALL hold the granted index throughout PLAY and GAP.
REQ-034 busy SHALL equal (state != IDLE).
REQ-035 Counter widths SHALL be 19-bit tone, 26-bit duration and 32-bit gap, with no wrap within legal ranges.

Reset
REQ-036 While reset=1, regardless of clock: state=IDLE, counters=0, phase=1, samples=0, req_accept=0, req_done=0, busy=0, active_id=3.
REQ-037 write_audio_out SHALL be 0 while reset=1.
REQ-038 Reset asserted mid-PLAY SHALL abort without a req_done pulse.
REQ-039 Operation SHALL resume at the first edge after reset deassertion.

Verification (GAP_CYCLES=4, AMPLITUDE=50000000)
REQ-040 Single request: req_valid=001, H=3, D=10 -> accept[0] in PLAY cycle 1; samples +5e7 x3, -5e7 x3, +5e7 x3, -5e7 x1; done[0] next cycle; busy high 14 cycles; then IDLE.
REQ-041 Priority: req_valid=110 asserted together -> requester 1 accepted first; requester 2, still held, accepted at the IDLE edge after requester 1's 4-cycle gap.
REQ-042 Request during PLAY: req_valid[0] rises mid-play of requester 2 -> no preemption; requester 0 accepted only after GAP.
REQ-043 Abort: enable=0 at PLAY cycle 5 -> IDLE next edge, sample 0, active_id=3, no done, write_audio_out=0.
REQ-044 Edge values: D=0 and H=0 -> one PLAY cycle at +5e7, then done; reset pulse mid-GAP -> all outputs to reset values immediately.
REQ-045 Streaming: audio_out_allowed toggling every cycle -> write_audio_out tracks it exactly while enable=1.

Source files
------------

// File: rtl/audio_sfx_scheduler.sv
// audio_sfx_scheduler
// Plays one square-wave sound effect at a time for up to three requesters.
// Index 0 has the highest priority. Each sound is followed by a silent gap.
// The scheduler streams samples (including zeros) to an audio controller.
//
// Ports
//   CLOCK_50                 : sole clock; all state changes on its rising edge
//   reset                    : asynchronous, active-high
//   enable                   : run enable; low aborts playback and returns to IDLE
//   req_valid[2:0]           : per-requester request, index 0 highest priority
//   req_half_period[56:0]    : 3 x 19-bit tone half-periods in clocks
//   req_duration[77:0]       : 3 x 26-bit durations in clocks
//   req_accept[2:0]          : one-cycle pulse in the first PLAY cycle of a grant
//   req_done[2:0]            : one-cycle pulse after the last PLAY cycle
//   busy                     : high in PLAY or GAP
//   active_id[1:0]           : requester being served, 2'd3 when none
//   audio_out_allowed        : output-FIFO space indication from the controller
//   write_audio_out          : sample write strobe (audio_out_allowed & enable)
//   left/right_channel_audio_out[31:0] : signed sample, identical on both channels
module audio_sfx_scheduler #(
  parameter logic [31:0] AMPLITUDE  = 32'd50000000,
  parameter logic [31:0] GAP_CYCLES = 32'd15000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  req_valid,
  input  logic [56:0] req_half_period,
  input  logic [77:0] req_duration,
  output logic [2:0]  req_accept,
  output logic [2:0]  req_done,
  output logic        busy,
  output logic [1:0]  active_id,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] SAMPLE_POS = AMPLITUDE;
  localparam logic [31:0] SAMPLE_NEG = 32'd0 - AMPLITUDE;

  state_t      state_r;
  logic [18:0] tone_cnt_r;
  logic [25:0] dur_cnt_r;
  logic [31:0] gap_cnt_r;
  logic        phase_r;
  logic [18:0] h_last_r;   // latched half-period minus one (0 and 1 both give 0)
  logic [25:0] d_last_r;   // latched duration minus one (0 and 1 both give 0)
  logic [31:0] sample_r;

  logic        grant_valid_s;
  logic [1:0]  grant_id_s;
  logic [18:0] grant_half_s;
  logic [25:0] grant_dur_s;
  logic        tone_wrap_s;
  logic        phase_next_s;
  logic        play_last_s;
  logic        gap_last_s;

  // Fixed-priority arbitration: lowest set index wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 2'd3;
    grant_half_s  = 19'd0;
    grant_dur_s   = 26'd0;
    if (req_valid[0]) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 2'd0;
      grant_half_s  = req_half_period[18:0];
      grant_dur_s   = req_duration[25:0];
    end else if (req_valid[1]) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 2'd1;
      grant_half_s  = req_half_period[37:19];
      grant_dur_s   = req_duration[51:26];
    end else if (req_valid[2]) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 2'd2;
      grant_half_s  = req_half_period[56:38];
      grant_dur_s   = req_duration[77:52];
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Terminal-count decodes for the tone, duration and gap counters.
  always_comb begin
    tone_wrap_s  = (tone_cnt_r == h_last_r);
    phase_next_s = tone_wrap_s ? ~phase_r : phase_r;
    play_last_s  = (dur_cnt_r == d_last_r);
    gap_last_s   = (gap_cnt_r == (GAP_CYCLES - 32'd1));
  end

  // Scheduler FSM with registered outputs; the sample register holds the
  // value for the cycle that follows each edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tone_cnt_r <= 19'd0;
      dur_cnt_r  <= 26'd0;
      gap_cnt_r  <= 32'd0;
      phase_r    <= 1'b1;
      h_last_r   <= 19'd0;
      d_last_r   <= 26'd0;
      sample_r   <= 32'd0;
      req_accept <= 3'b000;
      req_done   <= 3'b000;
      busy       <= 1'b0;
      active_id  <= 2'd3;
    end else begin
      req_accept <= 3'b000;
      req_done   <= 3'b000;
      if (!enable) begin
        // Abort: no done pulse for an interrupted sound.
        state_r    <= ST_IDLE;
        tone_cnt_r <= 19'd0;
        dur_cnt_r  <= 26'd0;
        gap_cnt_r  <= 32'd0;
        phase_r    <= 1'b1;
        sample_r   <= 32'd0;
        busy       <= 1'b0;
        active_id  <= 2'd3;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (grant_valid_s) begin
              state_r    <= ST_PLAY;
              h_last_r   <= (grant_half_s == 19'd0) ? 19'd0 : grant_half_s - 19'd1;
              d_last_r   <= (grant_dur_s == 26'd0) ? 26'd0 : grant_dur_s - 26'd1;
              tone_cnt_r <= 19'd0;
              dur_cnt_r  <= 26'd0;
              phase_r    <= 1'b1;
              sample_r   <= SAMPLE_POS;
              req_accept <= 3'b001 << grant_id_s;
              busy       <= 1'b1;
              active_id  <= grant_id_s;
            end else begin
              sample_r   <= 32'd0;
              busy       <= 1'b0;
              active_id  <= 2'd3;
            end
          end
          ST_PLAY: begin
            tone_cnt_r <= tone_wrap_s ? 19'd0 : tone_cnt_r + 19'd1;
            phase_r    <= phase_next_s;
            if (play_last_s) begin
              req_done <= 3'b001 << active_id;
              sample_r <= 32'd0;
              if (GAP_CYCLES == 32'd0) begin
                state_r   <= ST_IDLE;
                busy      <= 1'b0;
                active_id <= 2'd3;
              end else begin
                state_r   <= ST_GAP;
                gap_cnt_r <= 32'd0;
              end
            end else begin
              dur_cnt_r <= dur_cnt_r + 26'd1;
              sample_r  <= phase_next_s ? SAMPLE_POS : SAMPLE_NEG;
            end
          end
          ST_GAP: begin
            sample_r <= 32'd0;
            if (gap_last_s) begin
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
              active_id <= 2'd3;
            end else begin
              gap_cnt_r <= gap_cnt_r + 32'd1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sample_r  <= 32'd0;
            busy      <= 1'b0;
            active_id <= 2'd3;
          end
        endcase
      end
    end
  end

  // Write strobe follows the controller's space flag so zeros stream too.
  always_comb begin
    write_audio_out = audio_out_allowed & enable & ~reset;
  end

  assign left_channel_audio_out  = sample_r;
  assign right_channel_audio_out = sample_r;

endmodule
